// File: rtl/mdu_pkg.sv
// Shared MDU operation codes and HI/LO controller state encoding.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_ctrl.sv
// EX-stage multiply/divide control: owns HI/LO, runs MULT/MT* inline and
// sequences the external iterative divider, including flush draining.
module mdu_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        flush_i,
    input  logic [2:0]  mdu_op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        start_q, start_d, signed_q, signed_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    logic        accept, new_div;
    logic [63:0] prod_s, prod_u;

    assign prod_s = $signed({{32{rs_data_i[31]}}, rs_data_i}) *
                    $signed({{32{rt_data_i[31]}}, rt_data_i});
    assign prod_u = {32'd0, rs_data_i} * {32'd0, rt_data_i};

    assign accept  = ex_valid_i && !flush_i;
    assign new_div = accept && is_div_op(mdu_op_i);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        start_d  = start_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        stall_o  = 1'b0;

        // Single-cycle ops run in every state except WAIT, where the pipeline is frozen.
        if (accept && state_q != ST_WAIT) begin
            case (mdu_op_i)
                MDU_MULT:  {hi_d, lo_d} = prod_s;
                MDU_MULTU: {hi_d, lo_d} = prod_u;
                MDU_MTHI:  hi_d = rs_data_i;
                MDU_MTLO:  lo_d = rs_data_i;
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (new_div) begin
                    stall_o  = 1'b1;
                    op1_d    = rs_data_i;
                    op2_d    = rt_data_i;
                    signed_d = (mdu_op_i == MDU_DIV);
                    start_d  = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o = !div_ready_i;
                if (div_ready_i) begin
                    start_d = 1'b0;
                    state_d = ST_RELEASE;
                    if (!flush_i) begin
                        hi_d = div_result_i[63:32];
                        lo_d = div_result_i[31:0];
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            // Start must stay high here: dropping it early would leave the divider busy forever.
            ST_DRAIN: begin
                stall_o = new_div;
                if (div_ready_i) begin
                    start_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                stall_o = new_div;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 32'd1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            start_q    <= 1'b0;
            signed_q   <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            start_q    <= start_d;
            signed_q   <= signed_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Debug watchdog on a divider that never answers.
    always_ff @(posedge clk) begin
        if (!rst) assert (wait_cnt_q <= DIV_TIMEOUT);
    end

    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_start_o   = start_q;
    assign div_signed_o  = signed_q;
    assign div_opdata1_o = op1_q;
    assign div_opdata2_o = op2_q;

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
- EX-stage multiply/divide control unit and HI/LO register owner; sits directly upstream of the iterative divider.
- Issues DIV/DIVU to the divider and holds the start handshake until the result arrives.
- Stalls the pipeline while a divide is in flight, then writes HI/LO.
- Executes MULT/MULTU/MTHI/MTLO itself in one cycle.
- Handles pipeline flush mid-divide by draining the divider, so the next divide never picks up a stale result.

Parameters:
- DIV_TIMEOUT, 64: debug-only watchdog bound in cycles on the WAIT state. Exceeding it asserts a simulation error; no RTL effect.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid_i  in  1  new MDU instruction in EX; one pulse per instruction
- flush_i  in  1  kill the EX instruction and any divide in flight
- mdu_op_i  in  3  operation code (shared package)
- rs_data_i  in  32  operand 1 / MTHI/MTLO source
- rt_data_i  in  32  operand 2
- stall_o  out  1  hold IF/ID/EX
- hi_o  out  32  HI register
- lo_o  out  32  LO register
- div_start_o  out  1  divider start; registered
- div_signed_o  out  1  signed divide select; registered
- div_opdata1_o  out  32  dividend; registered
- div_opdata2_o  out  32  divisor; registered
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result valid

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States:
  - IDLE
  - WAIT: divide in flight, result wanted
  - DRAIN: divide in flight, result discarded
  - RELEASE: start held low for 1 cycle
- Divider protocol:
  - start stays high from issue until ready is seen.
  - start is then low for at least 1 cycle, so the divider returns to free.
  - ready never appears if start is dropped early, which is why DRAIN keeps start high.
- IDLE, ex_valid_i & !flush_i:
  - MULT/MULTU: {hi,lo} <= 64-bit signed/unsigned product of rs*rt at this edge; no stall.
  - MTHI: hi <= rs. MTLO: lo <= rs. No stall.
  - DIV/DIVU: stall_o=1 combinationally this cycle; latch operands; div_signed_o <= (op==DIV); div_start_o <= 1; go WAIT.
  - NOP: nothing.
- WAIT:
  - stall_o = !div_ready_i.
  - On div_ready_i & !flush_i: hi <= div_result_i[63:32], lo <= div_result_i[31:0]; div_start_o <= 0; go RELEASE.
  - On flush_i (any cycle, including the same cycle as ready): no HI/LO write.
    - If ready: drop start, go RELEASE.
    - Else: go DRAIN, start stays high.
- DRAIN:
  - stall_o=0, except a new valid DIV/DIVU stalls.
  - MULT/MTHI/MTLO execute normally.
  - On div_ready_i: drop start, go RELEASE.
- RELEASE:
  - start low; next cycle IDLE.
  - A new valid DIV/DIVU stalls 1 cycle and is accepted in IDLE; pipeline holds ex_valid_i while stalled.
  - Other ops execute.
- Divide by zero: no special case; HI/LO take the divider output (0,0).
- Latency: result visible on hi_o/lo_o the cycle after div_ready_i; worst case 40 cycles from issue.
- Simultaneous MTHI/MULT and divide completion: cannot occur in WAIT because the pipeline is stalled.
- Reset mid-divide: the divider shares rst; everything returns to reset values, no write.
- flush_i in IDLE: the op is ignored.

Decomposition:
- Package mdu_pkg:
  - mdu_op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - State encoding.
- No sub-module: the multiplier is an inline 64-bit product; the divider is instantiated by the parent, not inside this block.

Test Plan:
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> stall until ready; lo=0xFFFFFFFD, hi=0xFFFFFFFF; start low ≥1 cycle afterwards.
- DIVU rs=0xFFFFFFFF, rt=0x10 -> lo=0x0FFFFFFF, hi=0x0000000F. DIV by 0 -> hi=lo=0, completes in under 8 cycles.
- MULT rs=0xFFFFFFFF, rt=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, no stall. MULTU same operands -> hi=1, lo=0xFFFFFFFE. MTHI 0x1234 -> hi=0x1234, lo unchanged.
- DIV 100/7, flush 10 cycles after issue, then immediate DIVU 100/7 -> first divide's result never written; second stalls through DRAIN+RELEASE; final lo=14, hi=2.
- flush_i coincident with div_ready_i -> HI/LO unchanged; start drops; state returns to IDLE in 2 cycles.
- rst asserted mid-divide -> all outputs 0 next cycle; a subsequent DIVU 9/4 gives lo=2, hi=1.
